// File: rtl/hd44780_i2c_ctrl_if.sv
// Request port (user -> controller) and byte port (controller -> I2C writer)
// for the HD44780 backpack controller.
interface hd44780_i2c_ctrl_if #(
    parameter int ROW_W = 1,
    parameter int COL_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             req_rs;
    logic [7:0]       req_byte;
    logic             req_goto;
    logic [ROW_W-1:0] req_row;
    logic [COL_W-1:0] req_col;
    logic [6:0]       i2c_addr;
    logic             i2c_valid;
    logic             i2c_ready;
    logic [7:0]       i2c_data;
    logic             i2c_err;

    modport master (
        output req_valid, req_rs, req_byte, req_goto, req_row, req_col, i2c_ready, i2c_err,
        input  req_ready, i2c_addr, i2c_valid, i2c_data
    );
    modport slave (
        input  req_valid, req_rs, req_byte, req_goto, req_row, req_col, i2c_ready, i2c_err,
        output req_ready, i2c_addr, i2c_valid, i2c_data
    );
endinterface

// File: rtl/hd44780_i2c_ctrl.sv
// HD44780 4-bit controller over a PCF8574 I2C backpack: power-on init,
// byte/goto requests, cursor tracking with automatic row wrap.
module hd44780_i2c_ctrl #(
    parameter int         US_CYCLES = 100,
    parameter logic [6:0] I2C_ADDR  = 7'h27,
    parameter int         ROWS      = 2,
    parameter int         COLS      = 16,
    parameter int         CURSOR_ON = 0,
    parameter int         SIM       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    hd44780_i2c_ctrl_if.slave bus,
    input  logic              init_start,
    input  logic              backlight,
    output logic              busy,
    output logic              initialized,
    output logic              error
);
    localparam int          ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int          COL_W   = $clog2(COLS);
    localparam logic [7:0]  FN_SET  = (ROWS == 1) ? 8'h20 : 8'h28;
    localparam logic [7:0]  DISP_ON = (CURSOR_ON != 0) ? 8'h0F : 8'h0C;
    localparam logic [31:0] PWR_CYC = (SIM != 0) ? 32'd1 : 32'(40000 * US_CYCLES);

    typedef enum logic [2:0] {PWR_WAIT, IDLE, FETCH, SEND_E1, SEND_E0, WAIT} state_t;

    typedef struct packed {
        logic [31:0]      cnt;
        logic [3:0]       idx;
        logic             init;
        logic             req_pend;
        logic             goto_pend;
        logic             req_rs;
        logic [7:0]       req_byte;
        logic [7:0]       cmd;
        logic             rs;
        logic             hi;
        logic [15:0]      dly;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic             initialized;
        logic             error;
        logic             valid;
        logic [7:0]       data;
    } ctl_t;

    state_t r_state, w_state;
    ctl_t   r_ctl, w_ctl;

    logic [7:0]  w_src_byte;
    logic        w_src_rs;
    logic        w_src_hi;
    logic [15:0] w_src_dly;
    logic [3:0]  w_src_nib;
    logic [3:0]  w_nib;
    logic [31:0] w_dly_cyc;
    logic [7:0]  w_col_inc;

    // {command byte, post-delay in us}; entries 0..3 are lone nibbles
    function automatic logic [23:0] init_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    return {8'h03, 16'd4100};
            4'd1:    return {8'h03, 16'd100};
            4'd2:    return {8'h03, 16'd100};
            4'd3:    return {8'h02, 16'd100};
            4'd4:    return {FN_SET, 16'd53};
            4'd5:    return {8'h08, 16'd53};
            4'd6:    return {8'h01, 16'd2000};
            4'd7:    return {8'h06, 16'd53};
            default: return {DISP_ON, 16'd53};
        endcase
    endfunction

    function automatic logic [7:0] goto_cmd(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
        logic [7:0] off;
        off = (row[0] ? 8'h40 : 8'h00) + ((32'(row) > 1) ? 8'(COLS) : 8'h00);
        return 8'h80 | (off + 8'(col));
    endfunction

    assign w_nib     = r_ctl.hi ? r_ctl.cmd[7:4] : r_ctl.cmd[3:0];
    assign w_src_nib = w_src_hi ? w_src_byte[7:4] : w_src_byte[3:0];
    assign w_dly_cyc = (SIM != 0) ? 32'd1 : 32'(r_ctl.dly) * 32'(US_CYCLES);
    assign w_col_inc = 8'(r_ctl.col) + 8'd1;

    // Command source: init list, then a latched request, then a cursor goto
    always_comb begin
        w_src_byte = goto_cmd(r_ctl.row, r_ctl.col);
        w_src_rs   = 1'b0;
        w_src_hi   = 1'b1;
        w_src_dly  = 16'd53;
        if (r_ctl.init) begin
            {w_src_byte, w_src_dly} = init_entry(r_ctl.idx);
            w_src_hi = (r_ctl.idx >= 4'd4);
        end else if (r_ctl.req_pend) begin
            w_src_byte = r_ctl.req_byte;
            w_src_rs   = r_ctl.req_rs;
            w_src_dly  = (!r_ctl.req_rs && (r_ctl.req_byte inside {8'h01, 8'h02, 8'h03})) ? 16'd2000 : 16'd53;
        end
    end

    always_comb begin
        w_state = r_state;
        w_ctl   = r_ctl;
        case (r_state)
            PWR_WAIT: begin
                if (r_ctl.cnt == 32'd0) begin
                    w_state   = FETCH;
                    w_ctl.init = 1'b1;
                    w_ctl.idx  = 4'd0;
                end else if (bus.i2c_ready) begin
                    w_ctl.cnt = r_ctl.cnt - 32'd1;
                end
            end
            IDLE: begin
                if (init_start) begin
                    w_state           = FETCH;
                    w_ctl.init        = 1'b1;
                    w_ctl.idx         = 4'd0;
                    w_ctl.initialized = 1'b0;
                    w_ctl.error       = 1'b0;
                end else if (bus.req_valid && r_ctl.initialized) begin
                    w_state = FETCH;
                    if (bus.req_goto) begin
                        w_ctl.row       = (32'(bus.req_row) > ROWS - 1) ? ROW_W'(ROWS - 1) : bus.req_row;
                        w_ctl.col       = (32'(bus.req_col) > COLS - 1) ? COL_W'(COLS - 1) : bus.req_col;
                        w_ctl.goto_pend = 1'b1;
                    end else begin
                        w_ctl.req_pend = 1'b1;
                        w_ctl.req_rs   = bus.req_rs;
                        w_ctl.req_byte = bus.req_byte;
                        if (bus.req_rs) begin
                            if (w_col_inc == 8'(COLS)) begin
                                w_ctl.col       = '0;
                                w_ctl.row       = (32'(r_ctl.row) == ROWS - 1) ? '0 : r_ctl.row + ROW_W'(1);
                                w_ctl.goto_pend = 1'b1;
                            end else begin
                                w_ctl.col = COL_W'(w_col_inc);
                            end
                        end else if (bus.req_byte inside {8'h01, 8'h02, 8'h03}) begin
                            w_ctl.row = '0;
                            w_ctl.col = '0;
                        end
                    end
                end
            end
            FETCH: begin
                w_state   = SEND_E1;
                w_ctl.cmd = w_src_byte;
                w_ctl.rs  = w_src_rs;
                w_ctl.hi  = w_src_hi;
                w_ctl.dly = w_src_dly;
                if (!r_ctl.init) begin
                    if (r_ctl.req_pend) w_ctl.req_pend  = 1'b0;
                    else                w_ctl.goto_pend = 1'b0;
                end
                if (bus.i2c_ready) begin
                    w_ctl.valid = 1'b1;
                    w_ctl.data  = {w_src_nib, backlight, 2'b10, w_src_rs};
                end
            end
            SEND_E1: begin
                if (!r_ctl.valid) begin
                    if (bus.i2c_ready) begin
                        w_ctl.valid = 1'b1;
                        w_ctl.data  = {w_nib, backlight, 2'b10, r_ctl.rs};
                    end
                end else if (bus.i2c_ready) begin
                    w_ctl.valid = 1'b0;
                    w_state     = SEND_E0;
                end
            end
            SEND_E0: begin
                if (!r_ctl.valid) begin
                    if (bus.i2c_ready) begin
                        w_ctl.valid = 1'b1;
                        w_ctl.data  = {w_nib, backlight, 2'b00, r_ctl.rs};
                    end
                end else if (bus.i2c_ready) begin
                    w_ctl.valid = 1'b0;
                    if (r_ctl.hi) begin
                        w_ctl.hi = 1'b0;
                        w_state  = SEND_E1;
                    end else begin
                        w_ctl.cnt = w_dly_cyc;
                        w_state   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_ctl.cnt == 32'd0) begin
                    if (r_ctl.init) begin
                        if (r_ctl.idx == 4'd8) begin
                            w_ctl.init        = 1'b0;
                            w_ctl.initialized = 1'b1;
                            w_ctl.row         = '0;
                            w_ctl.col         = '0;
                            w_state           = IDLE;
                        end else begin
                            w_ctl.idx = r_ctl.idx + 4'd1;
                            w_state   = FETCH;
                        end
                    end else if (r_ctl.goto_pend) begin
                        w_state = FETCH;
                    end else begin
                        w_state = IDLE;
                    end
                end else if (bus.i2c_ready) begin
                    w_ctl.cnt = r_ctl.cnt - 32'd1;
                end
            end
            default: w_state = PWR_WAIT;
        endcase
        if (bus.i2c_err) w_ctl.error = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= PWR_WAIT;
            r_ctl     <= '0;
            r_ctl.cnt <= PWR_CYC;
        end else begin
            r_state <= w_state;
            r_ctl   <= w_ctl;
        end
    end

    assign bus.i2c_addr  = I2C_ADDR;
    assign bus.i2c_valid = r_ctl.valid;
    assign bus.i2c_data  = r_ctl.data;
    assign bus.req_ready = (r_state == IDLE) && r_ctl.initialized;
    assign busy          = (r_state != IDLE);
    assign initialized   = r_ctl.initialized;
    assign error         = r_ctl.error;
endmodule

// File: tb/tb_hd44780_i2c_ctrl.sv
// Directed bench: a fast SIM=1 2x16 instance and a real-delay 4x20 instance
// (US_CYCLES=1) share one clock and reset.
module tb_hd44780_i2c_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic bl;
    logic init_a, init_b;
    logic busy_a, done_a, err_a;
    logic busy_b, done_b, err_b;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    hd44780_i2c_ctrl_if #(.ROW_W(1), .COL_W(4)) ia ();
    hd44780_i2c_ctrl_if #(.ROW_W(2), .COL_W(5)) ib ();

    hd44780_i2c_ctrl #(.US_CYCLES(100), .I2C_ADDR(7'h27), .ROWS(2), .COLS(16), .CURSOR_ON(0), .SIM(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia), .init_start(init_a), .backlight(bl),
        .busy(busy_a), .initialized(done_a), .error(err_a));

    hd44780_i2c_ctrl #(.US_CYCLES(1), .I2C_ADDR(7'h3F), .ROWS(4), .COLS(20), .CURSOR_ON(1), .SIM(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib), .init_start(init_b), .backlight(bl),
        .busy(busy_b), .initialized(done_b), .error(err_b));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ia.i2c_valid && ia.i2c_ready) qa.push_back(ia.i2c_data);
        if (ib.i2c_valid && ib.i2c_ready) qb.push_back(ib.i2c_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req_a(input logic rs, input logic [7:0] b);
        int n = 0;
        while (!ia.req_ready && n < 200) begin @(negedge clk); n++; end
        chk("req_a_ready_timeout", 32'(n < 200), 1);
        ia.req_rs = rs; ia.req_byte = b; ia.req_goto = 1'b0; ia.req_valid = 1'b1;
        @(negedge clk);
        ia.req_valid = 1'b0;
    endtask

    task automatic req_b(input logic rs, input logic [7:0] b, input logic go, input logic [1:0] row, input logic [4:0] col);
        int n = 0;
        while (!ib.req_ready && n < 200) begin @(negedge clk); n++; end
        chk("req_b_ready_timeout", 32'(n < 200), 1);
        ib.req_rs = rs; ib.req_byte = b; ib.req_goto = go; ib.req_row = row; ib.req_col = col; ib.req_valid = 1'b1;
        @(negedge clk);
        ib.req_valid = 1'b0;
    endtask

    task automatic idle_a(input string tag);
        int n = 0;
        while (busy_a && n < 500) begin @(negedge clk); n++; end
        chk(tag, 32'(n < 500), 1);
    endtask

    initial begin
        logic [7:0] exp_init [28];
        logic [7:0] exp_wrap [8];
        logic [7:0] exp_goto [4];
        logic [7:0] exp_clr  [4];
        logic [7:0] d0;
        logic       stable;
        int         n;

        exp_init = '{8'h3C, 8'h38, 8'h3C, 8'h38, 8'h3C, 8'h38, 8'h2C, 8'h28,
                     8'h2C, 8'h28, 8'h8C, 8'h88, 8'h0C, 8'h08, 8'h8C, 8'h88,
                     8'h0C, 8'h08, 8'h1C, 8'h18, 8'h0C, 8'h08, 8'h6C, 8'h68,
                     8'h0C, 8'h08, 8'hCC, 8'hC8};
        exp_wrap = '{8'h55, 8'h51, 8'h05, 8'h01, 8'hC4, 8'hC0, 8'h04, 8'h00};
        exp_goto = '{8'hE4, 8'hE0, 8'h74, 8'h70};
        exp_clr  = '{8'h04, 8'h00, 8'h14, 8'h10};

        rst_n = 1'b0; bl = 1'b1; init_a = 1'b0; init_b = 1'b0;
        ia.req_valid = 1'b0; ia.req_rs = 1'b0; ia.req_byte = 8'h00; ia.req_goto = 1'b0;
        ia.req_row = '0; ia.req_col = '0; ia.i2c_ready = 1'b1; ia.i2c_err = 1'b0;
        ib.req_valid = 1'b0; ib.req_rs = 1'b0; ib.req_byte = 8'h00; ib.req_goto = 1'b0;
        ib.req_row = '0; ib.req_col = '0; ib.i2c_ready = 1'b1; ib.i2c_err = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", 32'(ia.req_ready), 0);
        chk("rst_i2c_valid", 32'(ia.i2c_valid), 0);
        chk("rst_i2c_data", 32'(ia.i2c_data), 32'h00);
        chk("rst_busy", 32'(busy_a), 1);
        chk("rst_initialized", 32'(done_a), 0);
        chk("rst_error", 32'(err_a), 0);
        chk("addr_a", 32'(ia.i2c_addr), 32'h27);
        chk("addr_b", 32'(ib.i2c_addr), 32'h3F);
        rst_n = 1'b1;

        // Init stream, fast instance
        n = 0;
        while (!done_a && n < 1000) begin @(negedge clk); n++; end
        chk("init_a_timeout", 32'(n < 1000), 1);
        chk("init_a_count", 32'(qa.size()), 28);
        for (int i = 0; i < 28; i++)
            if (i < qa.size()) chk($sformatf("init_a_byte%0d", i), 32'(qa[i]), 32'(exp_init[i]));
        chk("init_a_ready", 32'(ia.req_ready), 1);
        chk("pwr_wait_b_busy", 32'(busy_b), 1);
        chk("pwr_wait_b_init", 32'(done_b), 0);

        // Data write 'A', backlight off; check FETCH latency and valid drop
        bl = 1'b0;
        qa.delete();
        req_a(1'b1, 8'h41);
        chk("acc_ready_fall", 32'(ia.req_ready), 0);
        chk("acc_fetch_novalid", 32'(ia.i2c_valid), 0);
        @(negedge clk);
        chk("acc_first_valid", 32'(ia.i2c_valid), 1);
        chk("acc_first_data", 32'(ia.i2c_data), 32'h45);
        @(negedge clk);
        chk("valid_drop", 32'(ia.i2c_valid), 0);
        idle_a("data_idle_timeout");
        chk("data_count", 32'(qa.size()), 4);
        if (qa.size() == 4) begin
            chk("data_b1", 32'(qa[1]), 32'h41);
            chk("data_b2", 32'(qa[2]), 32'h15);
            chk("data_b3", 32'(qa[3]), 32'h11);
        end

        // Fill to column 15 without wrapping, then the 16th byte wraps
        qa.delete();
        for (int i = 1; i <= 14; i++) begin
            req_a(1'b1, 8'h41 + 8'(i));
            idle_a("fill_idle_timeout");
        end
        chk("fill_count", 32'(qa.size()), 56);
        qa.delete();
        req_a(1'b1, 8'h50);
        n = 0;
        while (!ia.req_ready && n < 200) begin @(negedge clk); n++; end
        chk("wrap_ready_timeout", 32'(n < 200), 1);
        chk("wrap_count", 32'(qa.size()), 8);
        for (int i = 0; i < 8; i++)
            if (i < qa.size()) chk($sformatf("wrap_byte%0d", i), 32'(qa[i]), 32'(exp_wrap[i]));

        // Error is sticky and leaves sequencing alone; init_start clears it
        ia.i2c_err = 1'b1;
        @(negedge clk);
        ia.i2c_err = 1'b0;
        @(negedge clk);
        chk("err_set", 32'(err_a), 1);
        chk("err_still_idle", 32'(busy_a), 0);
        bl = 1'b1;
        qa.delete();
        init_a = 1'b1;
        @(negedge clk);
        init_a = 1'b0;
        chk("reinit_err_clr", 32'(err_a), 0);
        chk("reinit_init_clr", 32'(done_a), 0);
        chk("reinit_busy", 32'(busy_a), 1);
        n = 0;
        while (qa.size() == 0 && n < 20) begin @(negedge clk); n++; end
        chk("reinit_first_timeout", 32'(n < 20), 1);
        if (qa.size() > 0) chk("reinit_first", 32'(qa[0]), 32'h3C);

        // Real-delay instance: clamped goto
        n = 0;
        while (!done_b && n < 60000) begin @(negedge clk); n++; end
        chk("init_b_timeout", 32'(n < 60000), 1);
        bl = 1'b0;
        qb.delete();
        req_b(1'b0, 8'h00, 1'b1, 2'd3, 5'd25);
        n = 0;
        while (!ib.req_ready && n < 300) begin @(negedge clk); n++; end
        chk("goto_timeout", 32'(n < 300), 1);
        chk("goto_count", 32'(qb.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < qb.size()) chk($sformatf("goto_byte%0d", i), 32'(qb[i]), 32'(exp_goto[i]));

        // Clear display with a 500-cycle stall on the first byte
        qb.delete();
        req_b(1'b0, 8'h01, 1'b0, 2'd0, 5'd0);
        n = 0;
        while (!ib.i2c_valid && n < 10) begin @(negedge clk); n++; end
        chk("stall_valid_timeout", 32'(n < 10), 1);
        ib.i2c_ready = 1'b0;
        d0 = ib.i2c_data;
        stable = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!(ib.i2c_valid === 1'b1 && ib.i2c_data === d0)) stable = 1'b0;
        end
        chk("stall_byte", 32'(d0), 32'h04);
        chk("stall_hold", 32'(stable), 1);
        chk("stall_no_accept", 32'(qb.size()), 0);
        ib.i2c_ready = 1'b1;
        n = 0;
        while (qb.size() < 4 && n < 100) begin @(negedge clk); n++; end
        chk("clr_bytes_timeout", 32'(n < 100), 1);
        for (int i = 0; i < 4; i++)
            if (i < qb.size()) chk($sformatf("clr_byte%0d", i), 32'(qb[i]), 32'(exp_clr[i]));
        n = 0;
        while (busy_b && n < 5000) begin n++; @(negedge clk); end
        chk("clr_delay_min", 32'(n >= 2000), 1);
        chk("clr_delay_max", 32'(n <= 2010), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
